// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared encodings for the two-source round-robin packet arbiter.
//   ST_IDLE / ST_GRANT0 / ST_GRANT1 : arbiter FSM state encoding
//   SEL_IN0 / SEL_IN1               : mux select values (0 = in0, 1 = in1)
//   grant_state()                   : maps a select value to its grant state
package mux_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  function automatic logic [1:0] grant_state(input logic sel);
    return (sel == SEL_IN1) ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/mux_arb_out_reg.sv
// mux_arb_out_reg: one-entry valid/ready output register holding data + last.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            an upstream beat is accepted this cycle (only when can_load)
//   in_data/in_last beat to capture on load
//   out_ready       downstream accepts the held beat
//   can_load        register is empty or is being drained this cycle
//   out_valid/out_data/out_last  registered beat toward the sink
module mux_arb_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          out_ready,
  output logic          can_load,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  logic          vld_p1;
  logic [DW-1:0] data_p1;
  logic          last_p1;

  assign can_load = !vld_p1 || out_ready;

  // ---- stage p1: registered output beat ----
  // The reset clears the data as well so an in-flight beat is fully discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data;
      last_p1 <= in_last;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: packet-granular round-robin arbiter sharing a 2:1 mux
// between sources in0 and in1, feeding one registered output stage.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in0_valid/in0_data/in0_last/in0_ready  source 0 handshake
//   in1_valid/in1_data/in1_last/in1_ready  source 1 handshake
//   out_valid/out_data/out_last/out_ready  sink handshake (registered)
//   s0                                registered mux select (0 = in0, 1 = in1)
//   busy                              high while a grant is held
// Optional feature: define MUX_ARB_HOLD_LIMIT_EN to cut a grant after
// MAX_BEATS accepted beats when the other source is waiting.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          s0,
  output logic          busy
);

  if (MAX_BEATS < 1) begin : g_bad_max_beats
    $error("MAX_BEATS must be >= 1");
  end

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          ptr;
  logic          sel;
  logic          can_load;
  logic          acc;
  logic          src_last;
  logic          limit_hit;
  logic          pkt_end;
  logic [DW-1:0] mux_data;

  // Only the granted source can see ready, so at most one of these is high.
  assign acc      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign mux_data = (sel == SEL_IN1) ? in1_data : in0_data;
  assign src_last = (sel == SEL_IN1) ? in1_last : in0_last;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic [CW-1:0] beat_cnt;
  logic [CW:0]   cnt_inc;
  logic          other_valid;

  assign cnt_inc     = {1'b0, beat_cnt} + (CW + 1)'(1);
  assign other_valid = (sel == SEL_IN1) ? in0_valid : in1_valid;
  // Cut only on the beat that reaches the limit, and only if someone is waiting.
  assign limit_hit   = acc && other_valid && (cnt_inc == (CW + 1)'(MAX_BEATS));

  // Saturates at MAX_BEATS so a long uncontended packet cannot wrap.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      beat_cnt <= '0;
    end else if (acc && cnt_inc <= (CW + 1)'(MAX_BEATS)) begin
      beat_cnt <= cnt_inc[CW-1:0];
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  assign pkt_end = acc && (src_last || limit_hit);

  // FSM state register, round-robin pointer and registered select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= SEL_IN0;
      sel   <= SEL_IN0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt != ST_IDLE) begin
        sel <= (state_nxt == ST_GRANT1) ? SEL_IN1 : SEL_IN0;
      end
      if (pkt_end) begin
        ptr <= ~sel;
      end
    end
  end

  // Next-state logic; IDLE always lasts at least one cycle between packets.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (in0_valid && in1_valid) begin
          state_nxt = grant_state(ptr);
        end else if (in0_valid) begin
          state_nxt = ST_GRANT0;
        end else if (in1_valid) begin
          state_nxt = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (pkt_end) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_GRANT0: begin
        in0_ready = can_load;
        busy      = 1'b1;
      end
      ST_GRANT1: begin
        in1_ready = can_load;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign s0 = sel;

  mux_arb_out_reg #(.DW(DW)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (acc),
    .in_data   (mux_data),
    .in_last   (src_last || limit_hit),
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: scoreboard bench for mux2_rr_arbiter.
// Expected beats are queued when a test sets up its stimulus and popped as
// the sink accepts beats. Build with MUX_ARB_HOLD_LIMIT_EN to exercise the
// beat-limit path (MAX_BEATS = 4).
module tb_mux2_rr_arbiter;

  localparam int DW = 8;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int MB = 4;
`else
  localparam int MB = 16;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in0_valid, in0_last, in0_ready;
  logic [DW-1:0] in0_data;
  logic          in1_valid, in1_last, in1_ready;
  logic [DW-1:0] in1_data;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
  logic          s0, busy;

  logic [8:0] sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DW(DW), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .s0        (s0),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_beat(input logic last, input logic [7:0] d);
    sb_q.push_back({last, d});
  endtask

  // Present one packet on a source, one beat per observed handshake.
  task automatic send(input int src, input logic [7:0] base, input int n);
    logic hit;
    for (int i = 0; i < n; i++) begin
      hit = 1'b0;
      if (src == 0) begin
        in0_valid = 1'b1; in0_data = base + 8'(i); in0_last = (i == n - 1);
      end else begin
        in1_valid = 1'b1; in1_data = base + 8'(i); in1_last = (i == n - 1);
      end
      for (int t = 0; t < 200 && !hit; t++) begin
        @(negedge clk);
        hit = (src == 0) ? in0_ready : in1_ready;
      end
      check("handshake", hit, 1);
      @(posedge clk); #1;
    end
    if (src == 0) begin
      in0_valid = 1'b0; in0_last = 1'b0;
    end else begin
      in1_valid = 1'b0; in1_last = 1'b0;
    end
  endtask

  task automatic idle_wait();
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pop and select stability within a grant.
  initial begin
    logic [8:0] exp_beat;
    logic       prev_busy = 1'b0;
    logic       prev_s0   = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_nonempty", sb_q.size(), 1);
        end else begin
          exp_beat = sb_q.pop_front();
          check("beat", {out_last, out_data}, exp_beat);
        end
      end
      if (prev_busy && busy === 1'b1) check("s0_stable", s0, prev_s0);
      prev_busy = (busy === 1'b1);
      prev_s0   = s0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h01; in0_last = 1'b1;
    in1_valid = 1'b1; in1_data = 8'h11; in1_last = 1'b1;

    // Reset with both sources requesting.
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_s0", s0, 0);
    check("rst_busy", busy, 0);
    check("rst_in0_ready", in0_ready, 0);
    check("rst_in1_ready", in1_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_beat(1'b1, 8'h01);
    expect_beat(1'b1, 8'h11);
    fork
      send(0, 8'h01, 1);
      send(1, 8'h11, 1);
      begin
        @(negedge clk);
        @(negedge clk);
        check("first_grant_busy", busy, 1);
        check("first_grant_s0", s0, 0);
        check("first_grant_in0_ready", in0_ready, 1);
        check("first_grant_in1_ready", in1_ready, 0);
      end
    join
    idle_wait();

    // Single source, 3-beat packet on in1.
    expect_beat(1'b0, 8'hA1);
    expect_beat(1'b0, 8'hA2);
    expect_beat(1'b1, 8'hA3);
    fork
      send(1, 8'hA1, 3);
      begin
        for (int t = 0; t < 20 && busy !== 1'b1; t++) @(negedge clk);
        check("t2_s0", s0, 1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("t2_out_valid", out_valid, 1);
          check("t2_out_data", out_data, 8'hA1 + 8'(k));
        end
        check("t2_idle", busy, 0);
      end
    join
    idle_wait();

    // Contention: both sources stream 2-beat packets.
    expect_beat(1'b0, 8'h20); expect_beat(1'b1, 8'h21);
    expect_beat(1'b0, 8'h30); expect_beat(1'b1, 8'h31);
    expect_beat(1'b0, 8'h22); expect_beat(1'b1, 8'h23);
    expect_beat(1'b0, 8'h32); expect_beat(1'b1, 8'h33);
    fork
      begin send(0, 8'h20, 2); send(0, 8'h22, 2); end
      begin send(1, 8'h30, 2); send(1, 8'h32, 2); end
    join
    idle_wait();

    // Backpressure for 3 cycles mid-packet.
    for (int i = 0; i < 4; i++) expect_beat(i == 3, 8'h40 + 8'(i));
    fork
      send(0, 8'h40, 4);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_out_valid", out_valid, 1);
          check("bp_out_data", out_data, 8'h41);
          check("bp_in0_ready", in0_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle_wait();

    // Reset pulsed while the second beat of an in1 packet is presented.
    expect_beat(1'b0, 8'h50);
    in1_valid = 1'b1; in1_data = 8'h50; in1_last = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    in1_data = 8'h51;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in1_valid = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_s0", s0, 0);
    check("mrst_in1_ready", in1_ready, 0);
    // ptr must be back at in0 even though in1 was next in line before reset.
    expect_beat(1'b1, 8'h60);
    expect_beat(1'b1, 8'h70);
    fork
      send(0, 8'h60, 1);
      send(1, 8'h70, 1);
    join
    idle_wait();

    // Long in0 packet while in1 waits.
`ifdef MUX_ARB_HOLD_LIMIT_EN
    expect_beat(1'b0, 8'h80); expect_beat(1'b0, 8'h81);
    expect_beat(1'b0, 8'h82); expect_beat(1'b1, 8'h83);
    expect_beat(1'b1, 8'h90);
    for (int i = 4; i < 10; i++) expect_beat(i == 9, 8'h80 + 8'(i));
`else
    for (int i = 0; i < 10; i++) expect_beat(i == 9, 8'h80 + 8'(i));
    expect_beat(1'b1, 8'h90);
`endif
    fork
      send(0, 8'h80, 10);
      send(1, 8'h90, 1);
    join
    idle_wait();

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
